// File: rtl/ssdec_scan.sv
// ssdec_scan: time-multiplexed seven-segment display driver.
//
// Holds an NDIGITS-wide hex value and shows it one digit at a time on
// common-segment displays. Each digit stays selected for SCAN_DIV cycles.
// The value is updated only at frame boundaries, so a frame never mixes old
// and new digits. Optional features: leading-zero suppression, per-digit
// blinking and per-digit decimal points.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   n_rst       asynchronous active-low reset
//   value       hex nibbles, nibble i = value[4i+3:4i], digit 0 least significant
//   load        one-cycle strobe, captures value into the pending register
//   enable      0 blanks the outputs (seg=0, an=0); scanning keeps running
//   blank_lz    1 suppresses leading zeros (digit 0 is never suppressed)
//   blink_mask  bit i = 1: digit i blinks
//   dp          bit i = 1: decimal point lit on digit i
//   seg         {dp, g, f, e, d, c, b, a}, active-high, registered
//   an          one-hot active-high digit select, registered
//   frame_done  one-cycle pulse in the cycle after each frame wrap
//
// Load semantics: load has no ready. It is accepted on every rising edge
// where it is high. The last load in a frame wins. A load on the frame-wrap
// edge goes straight to the displayed value.
module ssdec_scan #(
  parameter int NDIGITS      = 4,
  parameter int SCAN_DIV     = 100,
  parameter int BLINK_FRAMES = 25
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  input  logic                   enable,
  input  logic                   blank_lz,
  input  logic [NDIGITS-1:0]     blink_mask,
  input  logic [NDIGITS-1:0]     dp,
  output logic [7:0]             seg,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_done
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_t;

  logic [PRE_W-1:0]     prescaler;
  logic [IDX_W-1:0]     idx;
  logic [4*NDIGITS-1:0] pending;
  logic                 pend_v;
  logic [4*NDIGITS-1:0] active;
  logic [BLK_W-1:0]     blink_cnt;
  phase_t               phase;

  logic                 pre_wrap;
  logic                 frame_wrap;
  logic [3:0]           nib;
  logic [NDIGITS-1:0]   an_sel;
  logic [NDIGITS-1:0]   lz_vec;
  logic                 zero_above;
  logic                 lz_sel;
  logic                 blink_sel;
  logic                 dp_sel;
  logic                 digit_blank;
  logic [7:0]           seg_next;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h67;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  always_comb begin
    pre_wrap   = (prescaler == PRE_LAST);
    frame_wrap = pre_wrap && (idx == IDX_LAST);

    // lz_vec[i] is set when nibbles i..NDIGITS-1 are all zero. The loop
    // stops at 1 so digit 0 always shows its value.
    zero_above = 1'b1;
    lz_vec     = '0;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (active[4*i +: 4] == 4'h0);
      lz_vec[i]  = zero_above;
    end

    // Select the per-digit attributes of the digit currently scanned.
    nib       = 4'h0;
    an_sel    = '0;
    lz_sel    = 1'b0;
    blink_sel = 1'b0;
    dp_sel    = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = active[4*i +: 4];
        an_sel[i] = 1'b1;
        lz_sel    = lz_vec[i];
        blink_sel = blink_mask[i];
        dp_sel    = dp[i];
      end
    end

    digit_blank = (blank_lz && lz_sel) || ((phase == PH_OFF) && blink_sel);
    seg_next    = digit_blank ? 8'h00 : {dp_sel, glyph(nib)};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prescaler  <= '0;
      idx        <= '0;
      pending    <= '0;
      pend_v     <= 1'b0;
      active     <= '0;
      blink_cnt  <= '0;
      phase      <= PH_ON;
      seg        <= 8'h00;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      // Scan position
      if (pre_wrap) begin
        prescaler <= '0;
        idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end

      // Value path: the display value changes only at a frame wrap.
      if (load) begin
        pending <= value;
        if (frame_wrap) begin
          active <= value;
          pend_v <= 1'b0;
        end else begin
          pend_v <= 1'b1;
        end
      end else if (frame_wrap && pend_v) begin
        active <= pending;
        pend_v <= 1'b0;
      end

      // Blink phase advances once per frame.
      if (frame_wrap) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt <= '0;
          phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      // Registered outputs, one cycle behind the scan state.
      if (enable) begin
        seg <= seg_next;
        an  <= an_sel;
      end else begin
        seg <= 8'h00;
        an  <= '0;
      end
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: doc/ssdec_scan.md
# ssdec_scan

Parametrised, time-multiplexed seven-segment display driver for the game's score and level readouts. It holds an NDIGITS-wide hex value and scans it across NDIGITS common-segment digits, one digit at a time. It adds tear-free value update at frame boundaries, optional leading-zero suppression, per-digit blinking and per-digit decimal points. It sits between game control logic and the board's segment/anode pins, replacing one static decoder per digit.

## Interface
- NDIGITS, 4: number of digits scanned (1..8).
- SCAN_DIV, 100: clock cycles each digit stays selected (>= 2).
- BLINK_FRAMES, 25: frames per blink half-period (>= 1).

- clk  in  1  system clock, all state on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- value  in  4*NDIGITS  hex nibbles; nibble i = value[4i+3:4i], digit 0 least significant.
- load  in  1  one-cycle strobe; captures value into pending register.
- enable  in  1  0 blanks display (seg=0, an=0); scanning continues.
- blank_lz  in  1  1 suppresses leading zeros.
- blink_mask  in  NDIGITS  bit i = 1: digit i blinks.
- dp  in  NDIGITS  bit i = 1: decimal point lit on digit i.
- seg  out  8  {dp, g, f, e, d, c, b, a}, active-high.
- an  out  NDIGITS  one-hot active-high digit select.
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation
- Reset (asynchronous, n_rst=0) clears all state and outputs:
  - prescaler=0, idx=0, pending=0, pend_v=0, active=0, blink_cnt=0, phase=ON.
  - seg=0, an=0, frame_done=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and idx advances.
  - idx wraps from NDIGITS-1 to 0 ("frame wrap").
  - One frame = NDIGITS*SCAN_DIV cycles.
- Value path:
  - A load strobe sets pending<=value and pend_v<=1.
  - At a frame wrap, if pend_v=1: active<=pending and pend_v<=0.
  - Load on the same edge as a frame wrap: active<=value directly and pend_v<=0 (load wins).
  - Multiple loads within one frame: last one wins.
- Blink:
  - blink_cnt counts frame wraps 0..BLINK_FRAMES-1.
  - On its wrap, phase toggles ON/OFF.
  - In the OFF phase, digits with blink_mask set are fully blank (segments and dp).
- Leading-zero suppression:
  - Applies when blank_lz=1 and i>0.
  - Digit i is blank (segments and dp) if nibbles i..NDIGITS-1 of active are all zero.
  - Digit 0 is never suppressed.
- Glyphs, hex 0..F:
  - 3F 06 5B 4F 66 6D 7D 07 7F 67 77 7C 39 5E 79 71.
  - seg[7]=dp[idx] unless the digit is blanked.
- Output selection:
  - enable=0: seg=0, an=0.
  - Otherwise an=1<<idx and seg=the glyph/blank result for active nibble idx.
- blank_lz, blink_mask, dp and enable are sampled live each cycle; they are not frame-synchronised.

## Timing
- seg, an and frame_done are registered.
- Each reflects the state (idx, active, phase) of the previous cycle: 1-cycle latency.
- The first edge after reset release produces an=0001 and seg from active=0, i.e. glyph 3F.
- frame_done is high for exactly one cycle: the cycle after the frame-wrap edge.
- A new active value is first visible on digit 0, 1 cycle after the wrap edge.
- Digit segments never change mid-dwell because of load.
- enable 1->0 blanks outputs on the next edge; 0->1 resumes at the current idx with no restart.
- Reset asserted mid-frame clears immediately (asynchronous). Scanning restarts at idx=0 after release; a pending value is lost.

## Test plan
Setup for all scenarios: NDIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset, enable=1, no load -> an cycles 0001,0010,0100,1000, 4 cycles each; seg=3F throughout; frame_done pulses every 16 cycles.
- Load value=16'h1A3F mid-frame -> digits keep showing 0 until the next frame wrap; then digit0..3 show 71,4F,77,06.
- Load value=16'h0005 with blank_lz=1 -> digit0=6D, digits1-3 seg=00 with an still scanning. Same with blank_lz=0 -> digits1-3=3F.
- Load coincident with the frame-wrap edge (value 16'h2222) -> the next frame shows 5B on all digits; pend_v=0 afterward.
- blink_mask=4'b0010, dp=4'b0001 -> digit1 is shown for 2 frames and blank for 2 frames, repeating; digit0 seg[7]=1 throughout.
- Drop n_rst mid-dwell on idx=2 -> seg=0, an=0 and frame_done=0 immediately; after release, an=0001 on the first edge and active=0.
